cfeb_badbit_ctrl: RTL and testbench

- Control and collection end of the CFEB stuck-bit detection interface.
- Drives the check pulse, checker reset and single-bx mode into an array of per-bit stuck-bit checkers, then gathers their bad-bit flags into a registered mask, a count and an any-bad summary.
- One instance per CFEB, placed between the VME configuration registers and the CFEB triad bit-check array.

---
 rtl/cfeb_badbit_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_cfeb_badbit_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfeb_badbit_ctrl.sv
// cfeb_badbit_ctrl
// Control and collection end of the CFEB stuck-bit detection interface.
// Sequences the per-bit checkers (checker reset, periodic check pulse,
// single-bx mode) and collects their sticky bad-bit flags into a registered
// mask, a popcount and an any-bad summary.
//
// Optional feature macro: CFEB_BADBIT_TSTAMP_EN
//   When defined, adds output first_bad_chk and a 16-bit saturating count of
//   check pulses issued since the last CLEAR. first_bad_chk records that
//   count on the first cycle badbit_any is seen high after a CLEAR.
//
// State table:
//   state  | meaning
//   IDLE   | checking stopped; results hold
//   CLEAR  | checker_reset high for CLR_CYC cycles; results cleared on entry
//   RUN    | periodic check pulses; mask follows bit_bad
module cfeb_badbit_ctrl #(
  parameter int NBITS   = 48,
  parameter int CNT_W   = 6,
  parameter int PER_W   = 16,
  parameter int CLR_CYC = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             check_en,
  input  logic             badbit_reset,
  input  logic [PER_W-1:0] period,
  input  logic             single_bx_in,
  input  logic [NBITS-1:0] bit_bad,
  output logic             check_pulse,
  output logic             checker_reset,
  output logic             single_bx_mode,
  output logic [NBITS-1:0] badbit_mask,
  output logic [CNT_W-1:0] badbit_count,
  output logic             badbit_any,
`ifdef CFEB_BADBIT_TSTAMP_EN
  output logic [PER_W-1:0] first_bad_chk,
`endif
  output logic             busy
);

  localparam int CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CLEAR = 2'b01,
    S_RUN   = 2'b10
  } state_t;

  state_t             state_q;
  logic [CLR_W-1:0]   clr_cnt_q;
  logic [PER_W-1:0]   per_cnt_q;
  logic               check_pulse_q;
  logic               checker_reset_q;
  logic               single_bx_q;
  logic [NBITS-1:0]   mask_q;
  logic [CNT_W-1:0]   count_q;
  logic               any_q;

  logic               enter_clear_d;
  logic [PER_W-1:0]   reload_d;
  logic [CNT_W-1:0]   popcount_d;

  // CLEAR is entered on a badbit_reset from any state, or on check_en from IDLE;
  // the reload value maps period 0 and 1 alike to a pulse every cycle.
  always_comb begin
    enter_clear_d = badbit_reset || ((state_q == S_IDLE) && check_en);
    reload_d      = (period == '0) ? '0 : (period - PER_W'(1));
  end

  // Popcount of the registered mask feeding the count pipeline stage.
  always_comb begin
    popcount_d = '0;
    for (int i = 0; i < NBITS; i++) begin
      popcount_d = popcount_d + CNT_W'(mask_q[i]);
    end
  end

  // Main sequencer with registered checker controls and mask capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      clr_cnt_q       <= '0;
      per_cnt_q       <= '0;
      check_pulse_q   <= 1'b0;
      checker_reset_q <= 1'b0;
      single_bx_q     <= 1'b0;
      mask_q          <= '0;
    end else begin
      check_pulse_q <= 1'b0;
      if (enter_clear_d) begin
        state_q         <= S_CLEAR;
        clr_cnt_q       <= CLR_W'(CLR_CYC - 1);
        checker_reset_q <= 1'b1;
        single_bx_q     <= single_bx_in;
        mask_q          <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            checker_reset_q <= 1'b0;
          end
          S_CLEAR: begin
            if (clr_cnt_q == '0) begin
              checker_reset_q <= 1'b0;
              if (check_en) begin
                state_q   <= S_RUN;
                per_cnt_q <= reload_d;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              clr_cnt_q <= clr_cnt_q - CLR_W'(1);
            end
          end
          S_RUN: begin
            if (!check_en) begin
              // Leaving RUN freezes the mask at its last captured value.
              state_q <= S_IDLE;
            end else begin
              mask_q <= bit_bad;
              if (per_cnt_q == '0) begin
                check_pulse_q <= 1'b1;
                per_cnt_q     <= reload_d;
              end else begin
                per_cnt_q <= per_cnt_q - PER_W'(1);
              end
            end
          end
          default: begin
            state_q         <= S_IDLE;
            checker_reset_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Count and any-bad are one register stage behind the mask; cleared on CLEAR entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      any_q   <= 1'b0;
    end else if (enter_clear_d) begin
      count_q <= '0;
      any_q   <= 1'b0;
    end else begin
      count_q <= popcount_d;
      any_q   <= |mask_q;
    end
  end

`ifdef CFEB_BADBIT_TSTAMP_EN
  logic [15:0]      chk_cnt_q;
  logic [PER_W-1:0] first_bad_q;
  logic             captured_q;

  // Counts pulses already issued; captures once per CLEAR when badbit_any first shows high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chk_cnt_q   <= '0;
      first_bad_q <= '0;
      captured_q  <= 1'b0;
    end else if (enter_clear_d) begin
      chk_cnt_q   <= '0;
      first_bad_q <= '0;
      captured_q  <= 1'b0;
    end else begin
      if (check_pulse_q && (chk_cnt_q != 16'hFFFF)) begin
        chk_cnt_q <= chk_cnt_q + 16'd1;
      end
      if (any_q && !captured_q) begin
        first_bad_q <= PER_W'(chk_cnt_q);
        captured_q  <= 1'b1;
      end
    end
  end

  assign first_bad_chk = first_bad_q;
`endif

  assign check_pulse    = check_pulse_q;
  assign checker_reset  = checker_reset_q;
  assign single_bx_mode = single_bx_q;
  assign badbit_mask    = mask_q;
  assign badbit_count   = count_q;
  assign badbit_any     = any_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_cfeb_badbit_ctrl.sv
// Testbench for cfeb_badbit_ctrl. Stimulus pushes time-tagged expectations
// (cycle, field, value) into a scoreboard queue; a monitor on the falling
// edge pops and compares every entry due in the current cycle.
module tb_cfeb_badbit_ctrl;

  localparam int NBITS   = 48;
  localparam int CNT_W   = 6;
  localparam int PER_W   = 16;
  localparam int CLR_CYC = 2;

  localparam int F_PULSE = 0;
  localparam int F_CRST  = 1;
  localparam int F_SBX   = 2;
  localparam int F_MASK  = 3;
  localparam int F_COUNT = 4;
  localparam int F_ANY   = 5;
  localparam int F_BUSY  = 6;
  localparam int F_TS    = 7;

  logic             clock;
  logic             reset_n;
  logic             check_en;
  logic             badbit_reset;
  logic [PER_W-1:0] period;
  logic             single_bx_in;
  logic [NBITS-1:0] bit_bad;
  logic             check_pulse;
  logic             checker_reset;
  logic             single_bx_mode;
  logic [NBITS-1:0] badbit_mask;
  logic [CNT_W-1:0] badbit_count;
  logic             badbit_any;
  logic             busy;
`ifdef CFEB_BADBIT_TSTAMP_EN
  logic [PER_W-1:0] first_bad_chk;
`endif

  cfeb_badbit_ctrl #(
    .NBITS(NBITS), .CNT_W(CNT_W), .PER_W(PER_W), .CLR_CYC(CLR_CYC)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .check_en       (check_en),
    .badbit_reset   (badbit_reset),
    .period         (period),
    .single_bx_in   (single_bx_in),
    .bit_bad        (bit_bad),
    .check_pulse    (check_pulse),
    .checker_reset  (checker_reset),
    .single_bx_mode (single_bx_mode),
    .badbit_mask    (badbit_mask),
    .badbit_count   (badbit_count),
    .badbit_any     (badbit_any),
`ifdef CFEB_BADBIT_TSTAMP_EN
    .first_bad_chk  (first_bad_chk),
`endif
    .busy           (busy)
  );

  typedef struct {
    int          cyc;
    int          fld;
    logic [63:0] val;
  } exp_t;

  exp_t sbq[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic string fname(input int f);
    case (f)
      F_PULSE: return "check_pulse";
      F_CRST:  return "checker_reset";
      F_SBX:   return "single_bx_mode";
      F_MASK:  return "badbit_mask";
      F_COUNT: return "badbit_count";
      F_ANY:   return "badbit_any";
      F_BUSY:  return "busy";
      default: return "first_bad_chk";
    endcase
  endfunction

  function automatic logic [63:0] actual(input int f);
    case (f)
      F_PULSE: return 64'(check_pulse);
      F_CRST:  return 64'(checker_reset);
      F_SBX:   return 64'(single_bx_mode);
      F_MASK:  return 64'(badbit_mask);
      F_COUNT: return 64'(badbit_count);
      F_ANY:   return 64'(badbit_any);
      F_BUSY:  return 64'(busy);
`ifdef CFEB_BADBIT_TSTAMP_EN
      F_TS:    return 64'(first_bad_chk);
`endif
      default: return 64'hDEAD;
    endcase
  endfunction

  task automatic expect_at(input int dcyc, input int f, input logic [63:0] v);
    exp_t e;
    e.cyc = cyc + dcyc;
    e.fld = f;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: compare every expectation due this cycle, flag any that were skipped.
  always @(negedge clock) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc == cyc) begin
        checks++;
        if (actual(sbq[i].fld) !== sbq[i].val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%0h expected=%0h",
                   fname(sbq[i].fld), cyc, actual(sbq[i].fld), sbq[i].val);
        end
        sbq.delete(i);
      end else if (sbq[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s cyc=%0d not sampled (due %0d)",
                 fname(sbq[i].fld), cyc, sbq[i].cyc);
        sbq.delete(i);
      end
    end
  end

  logic [NBITS-1:0] bb;

  initial begin
    reset_n      = 1'b0;
    check_en     = 1'b0;
    badbit_reset = 1'b0;
    period       = 16'd4;
    single_bx_in = 1'b0;
    bit_bad      = '0;
    step(3);
    reset_n = 1'b1;
    step(2);

    // Idle after reset
    expect_at(0, F_BUSY, 0);
    expect_at(0, F_COUNT, 0);
    expect_at(0, F_MASK, 0);
    expect_at(0, F_CRST, 0);
    expect_at(0, F_PULSE, 0);
    expect_at(0, F_SBX, 0);
    step(1);

    // Start with period 4: CLEAR for 2 cycles, RUN from +3, pulses every 4th cycle
    period   = 16'd4;
    check_en = 1'b1;
    expect_at(0, F_CRST, 0);
    expect_at(1, F_CRST, 1);
    expect_at(2, F_CRST, 1);
    expect_at(3, F_CRST, 0);
    expect_at(1, F_BUSY, 1);
    expect_at(3, F_BUSY, 1);
    for (int j = 0; j <= 20; j++)
      expect_at(3 + j, F_PULSE, ((j != 0) && (j % 4 == 0)) ? 64'd1 : 64'd0);
    step(10);

    // single_bx_in toggled in RUN is ignored
    single_bx_in = 1'b1;
    step(2);
    single_bx_in = 1'b0;
    step(1);
    single_bx_in = 1'b1;
    expect_at(1, F_SBX, 0);
    expect_at(3, F_SBX, 0);
    step(10);

    // bit 3 and bit 47 bad: mask after 1 cycle, count/any after 2
    bb     = '0;
    bb[3]  = 1'b1;
    bb[47] = 1'b1;
    bit_bad = bb;
    expect_at(0, F_MASK, 0);
    expect_at(1, F_MASK, 64'(bb));
    expect_at(1, F_COUNT, 0);
    expect_at(1, F_ANY, 0);
    expect_at(2, F_COUNT, 2);
    expect_at(2, F_ANY, 1);
    step(3);

    // badbit_reset together with check_en falling: CLEAR then IDLE, single_bx latched
    badbit_reset = 1'b1;
    check_en     = 1'b0;
    expect_at(0, F_SBX, 0);
    expect_at(1, F_SBX, 1);
    expect_at(1, F_CRST, 1);
    expect_at(2, F_CRST, 1);
    expect_at(3, F_CRST, 0);
    expect_at(1, F_MASK, 0);
    expect_at(1, F_COUNT, 0);
    expect_at(1, F_ANY, 0);
    expect_at(2, F_COUNT, 0);
    expect_at(2, F_BUSY, 1);
    expect_at(3, F_BUSY, 0);
    expect_at(5, F_MASK, 0);
    expect_at(5, F_SBX, 1);
    for (int j = 1; j <= 5; j++) expect_at(j, F_PULSE, 0);
    step(1);
    badbit_reset = 1'b0;
    step(5);

    // period 0: pulse every cycle in RUN
    bit_bad      = '0;
    single_bx_in = 1'b0;
    period       = 16'd0;
    check_en     = 1'b1;
    expect_at(1, F_SBX, 0);
    expect_at(3, F_PULSE, 0);
    for (int j = 1; j <= 12; j++) expect_at(3 + j, F_PULSE, 1);
    step(3);
    step(6);
    // Raised at RUN+6: sampled on the edge issuing the 7th pulse; 7 pulses
    // precede the cycle badbit_any rises.
    bb      = '0;
    bb[0]   = 1'b1;
    bit_bad = bb;
    expect_at(1, F_MASK, 1);
    expect_at(2, F_COUNT, 1);
    expect_at(2, F_ANY, 1);
`ifdef CFEB_BADBIT_TSTAMP_EN
    expect_at(2, F_TS, 0);
    expect_at(3, F_TS, 7);
    expect_at(6, F_TS, 7);
`endif
    step(7);

    // All bits bad, then asynchronous reset mid-RUN
    bit_bad = '1;
    expect_at(1, F_MASK, 64'({NBITS{1'b1}}));
    expect_at(2, F_COUNT, 48);
    expect_at(2, F_ANY, 1);
    step(3);
    #1 reset_n = 1'b0;
    expect_at(0, F_MASK, 0);
    expect_at(0, F_COUNT, 0);
    expect_at(0, F_ANY, 0);
    expect_at(0, F_BUSY, 0);
    expect_at(0, F_CRST, 0);
    expect_at(0, F_PULSE, 0);
    expect_at(0, F_SBX, 0);
`ifdef CFEB_BADBIT_TSTAMP_EN
    expect_at(0, F_TS, 0);
`endif
    check_en = 1'b0;
    bit_bad  = '0;
    step(1);
    reset_n = 1'b1;
    expect_at(1, F_BUSY, 0);
    expect_at(1, F_COUNT, 0);
    expect_at(2, F_BUSY, 0);
    expect_at(2, F_MASK, 0);
    step(4);

    while (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s never sampled (due %0d)", fname(sbq[0].fld), sbq[0].cyc);
      void'(sbq.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
